// File: rtl/count_seq_ctrl.sv
// count_seq_ctrl: limited-run step sequencer over a WIDTH-bit register.
// Steps up, down, Gray-up or one-hot ring; supports pause/resume and load.
module count_seq_ctrl #(
  parameter int WIDTH = 3,
  parameter int LIMW  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       mode,
  input  logic [LIMW-1:0]  limit,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             step_en,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  q_q, q_d;
  logic [1:0]        mode_q, mode_d;
  logic [LIMW-1:0]   lim_q, lim_d;
  logic [LIMW-1:0]   cnt_q, cnt_d;
  logic [LIMW-1:0]   cnt_inc;
  logic              step_q, step_d;
  logic              done_q, done_d;
  logic              last;

  function automatic logic [WIDTH-1:0] next_val(
    input logic [WIDTH-1:0] v,
    input logic [1:0]       m
  );
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] r;
    b = '0;
    r = v;
    case (m)
      2'b00: r = v + WIDTH'(1);
      2'b01: r = v - WIDTH'(1);
      2'b10: begin
        b[WIDTH-1] = v[WIDTH-1];
        for (int i = WIDTH-2; i >= 0; i--) begin
          b[i] = b[i+1] ^ v[i];
        end
        b = b + WIDTH'(1);
        r = b ^ (b >> 1);
      end
      default: begin
        if (v == '0) r = WIDTH'(1);
        else         r = {v[WIDTH-2:0], v[WIDTH-1]};
      end
    endcase
    return r;
  endfunction

  assign cnt_inc = cnt_q + LIMW'(1);
  assign last    = (lim_q != '0) && (cnt_inc == lim_q);

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    mode_d  = mode_q;
    lim_d   = lim_q;
    cnt_d   = cnt_q;
    step_d  = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (load_en) q_d = load_val;
        if (start) begin
          state_d = S_RUN;
          mode_d  = mode;
          lim_d   = limit;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_PAUSE;
        end else begin
          q_d    = next_val(q_q, mode_q);
          step_d = 1'b1;
          // free-run saturates so the count never wraps
          if (cnt_q != '1) cnt_d = cnt_inc;
          if (last) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end
      S_PAUSE: begin
        if (start) state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      mode_q  <= '0;
      lim_q   <= '0;
      cnt_q   <= '0;
      step_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      mode_q  <= mode_d;
      lim_q   <= lim_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      done_q  <= done_d;
    end
  end

  assign q       = q_q;
  assign busy    = (state_q == S_RUN) || (state_q == S_PAUSE);
  assign step_en = step_q;
  assign done    = done_q;

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Self-checking bench for count_seq_ctrl: directed scenarios plus
// randomized runs compared with an arithmetic reference model.
module tb_count_seq_ctrl;
  localparam int W    = 3;
  localparam int L    = 8;
  localparam int MASK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic [L-1:0] limit = '0;
  logic         load_en = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] q;
  logic         busy;
  logic         step_en;
  logic         done;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  count_seq_ctrl #(.WIDTH(W), .LIMW(L)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .mode     (mode),
    .limit    (limit),
    .load_en  (load_en),
    .load_val (load_val),
    .q        (q),
    .busy     (busy),
    .step_en  (step_en),
    .done     (done)
  );

  // Reference step rule, from plain integer arithmetic.
  function automatic int m_next(input int v, input int m);
    int bin;
    int t;
    case (m)
      0: return (v + 1) & MASK;
      1: return (v - 1) & MASK;
      2: begin
        bin = 0;
        for (t = v; t != 0; t = t >> 1) bin = bin ^ t;
        bin = (bin + 1) & MASK;
        return bin ^ (bin >> 1);
      end
      default: begin
        if (v == 0) return 1;
        return ((v << 1) | (v >> (W - 1))) & MASK;
      end
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; load_en = 1'b1; load_val = 3'd5;
    tick; tick;
    n_cmp++;
    if (q !== 3'd0) begin
      n_bad++; $display("FAIL reset_q got %0d want 0", q);
    end
    n_cmp++;
    if ({busy, step_en, done} !== 3'b000) begin
      n_bad++; $display("FAIL reset_flags got %b want 000", {busy, step_en, done});
    end
    rst = 1'b0; start = 1'b0;
    tick;
    n_cmp++;
    if (q !== 3'd5 || busy !== 1'b0) begin
      n_bad++; $display("FAIL idle_load got q=%0d busy=%b want 5/0", q, busy);
    end
    load_en = 1'b0; load_val = 3'd2;
    tick;
    n_cmp++;
    if (q !== 3'd5) begin
      n_bad++; $display("FAIL idle_hold got %0d want 5", q);
    end
  endtask

  task automatic test_limited_run(input string nm, input logic [1:0] m,
                                  input int lim, input bit ld,
                                  input logic [W-1:0] lv,
                                  input int exp[6], input int n);
    logic [W-1:0] e;
    logic [W-1:0] q0;
    rst = 1'b1; tick; rst = 1'b0;
    mode = m; limit = L'(lim); load_en = ld; load_val = lv; start = 1'b1;
    tick;
    start = 1'b0; load_en = 1'b0;
    q0 = ld ? lv : '0;
    n_cmp++;
    if (q !== q0 || busy !== 1'b1 || step_en !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_start got q=%0d busy=%b se=%b want %0d/1/0",
               nm, q, busy, step_en, q0);
    end
    mode = ~m; limit = 8'd1; load_val = ~lv;
    for (int i = 0; i < n; i++) begin
      tick;
      e = W'(exp[i]);
      n_cmp++;
      if (q !== e || step_en !== 1'b1 || done !== (i == n - 1)
          || busy !== (i != n - 1)) begin
        n_bad++;
        $display("FAIL %s_step%0d got q=%0d se=%b done=%b busy=%b want q=%0d",
                 nm, i + 1, q, step_en, done, busy, e);
      end
    end
    tick;
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0 || step_en !== 1'b0 || q !== e) begin
      n_bad++;
      $display("FAIL %s_after got q=%0d se=%b done=%b busy=%b want q=%0d 000",
               nm, q, step_en, done, busy, e);
    end
    tick;
    n_cmp++;
    if (q !== e || busy !== 1'b0) begin
      n_bad++; $display("FAIL %s_idle_hold got q=%0d want %0d", nm, q, e);
    end
    mode = 2'b00; limit = '0;
  endtask

  task automatic test_pause;
    rst = 1'b1; tick; rst = 1'b0;
    mode = 2'b00; limit = 8'd6; start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      tick;
      n_cmp++;
      if (q !== W'(i)) begin
        n_bad++; $display("FAIL pause_pre%0d got %0d want %0d", i, q, i);
      end
    end
    mode = 2'b01; limit = 8'd2;
    for (int c = 0; c < 3; c++) begin
      stop = (c != 1);
      tick;
      n_cmp++;
      if (q !== 3'd2 || busy !== 1'b1 || step_en !== 1'b0 || done !== 1'b0) begin
        n_bad++;
        $display("FAIL pause_hold%0d got q=%0d busy=%b se=%b done=%b want 2/1/0/0",
                 c, q, busy, step_en, done);
      end
    end
    stop = 1'b0; start = 1'b1;
    tick;
    start = 1'b0;
    n_cmp++;
    if (q !== 3'd2 || busy !== 1'b1 || step_en !== 1'b0) begin
      n_bad++;
      $display("FAIL pause_resume got q=%0d busy=%b se=%b want 2/1/0", q, busy, step_en);
    end
    for (int i = 3; i <= 6; i++) begin
      tick;
      n_cmp++;
      if (q !== W'(i) || step_en !== 1'b1 || done !== (i == 6)) begin
        n_bad++;
        $display("FAIL pause_post%0d got q=%0d se=%b done=%b", i, q, step_en, done);
      end
    end
    start = 1'b1;
    tick;
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || q !== 3'd6) begin
      n_bad++;
      $display("FAIL done_ignores_start got busy=%b done=%b q=%0d want 0/0/6",
               busy, done, q);
    end
    mode = 2'b00; limit = '0;
  endtask

  task automatic test_rst_mid;
    int dseen;
    rst = 1'b1; tick; rst = 1'b0;
    mode = 2'b00; limit = 8'd4; start = 1'b1;
    tick;
    start = 1'b0;
    tick; tick; tick;
    n_cmp++;
    if (q !== 3'd3 || busy !== 1'b1) begin
      n_bad++; $display("FAIL rstmid_pre got q=%0d busy=%b want 3/1", q, busy);
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    n_cmp++;
    if (q !== 3'd0 || busy !== 1'b0 || done !== 1'b0 || step_en !== 1'b0) begin
      n_bad++;
      $display("FAIL rstmid_clear got q=%0d busy=%b done=%b se=%b want 0/0/0/0",
               q, busy, done, step_en);
    end
    dseen = 0;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (done !== 1'b0 || busy !== 1'b0 || q !== 3'd0) dseen++;
    end
    n_cmp++;
    if (dseen != 0) begin
      n_bad++; $display("FAIL rstmid_quiet got %0d bad cycles want 0", dseen);
    end
    limit = '0;
  endtask

  task automatic test_random(input int runs);
    int mq, steps, lim, m;
    bit paused, fin, stepped;
    rst = 1'b1; tick; rst = 1'b0;
    mq = 0;
    for (int r = 0; r < runs; r++) begin
      m = $urandom_range(3);
      lim = $urandom_range(12);
      mode = 2'(m); limit = L'(lim);
      load_en = 1'($urandom_range(1)); load_val = W'($urandom_range(MASK));
      stop = 1'($urandom_range(1));
      start = 1'b1;
      if (load_en) mq = int'(load_val);
      tick;
      start = 1'b0; load_en = 1'b0; stop = 1'b0;
      n_cmp++;
      if (q !== W'(mq) || busy !== 1'b1 || step_en !== 1'b0 || done !== 1'b0) begin
        n_bad++;
        $display("FAIL rnd%0d_start got q=%0d busy=%b want %0d/1", r, q, busy, mq);
      end
      steps = 0; paused = 0; fin = 0;
      for (int c = 0; c < 60 && !fin; c++) begin
        stop = ($urandom_range(3) == 0);
        start = 1'($urandom_range(1));
        mode = 2'($urandom_range(3));
        limit = L'($urandom_range(255));
        load_en = 1'($urandom_range(1));
        load_val = W'($urandom_range(MASK));
        tick;
        stepped = 0;
        if (!paused) begin
          if (stop) paused = 1;
          else begin
            mq = m_next(mq, m);
            steps++;
            stepped = 1;
            if (lim != 0 && steps == lim) fin = 1;
          end
        end else if (start) begin
          paused = 0;
        end
        n_cmp++;
        if (q !== W'(mq) || step_en !== stepped || done !== fin || busy !== !fin) begin
          n_bad++;
          $display("FAIL rnd%0d_c%0d m=%0d got q=%0d se=%b done=%b busy=%b want q=%0d se=%b done=%b",
                   r, c, m, q, step_en, done, busy, mq, stepped, fin);
        end
      end
      if (fin) begin
        start = 1'b1; load_en = 1'b1; load_val = W'(~mq);
        tick;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || q !== W'(mq)) begin
          n_bad++;
          $display("FAIL rnd%0d_done_exit got q=%0d busy=%b done=%b want %0d/0/0",
                   r, q, busy, done, mq);
        end
      end else begin
        rst = 1'b1;
        tick;
        mq = 0;
        n_cmp++;
        if (q !== '0 || busy !== 1'b0 || done !== 1'b0 || step_en !== 1'b0) begin
          n_bad++;
          $display("FAIL rnd%0d_rst got q=%0d busy=%b done=%b", r, q, busy, done);
        end
      end
      rst = 1'b0; start = 1'b0; load_en = 1'b0; stop = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_limited_run("up", 2'b00, 5, 1'b0, 3'd0, '{1, 2, 3, 4, 5, 0}, 5);
    test_limited_run("down", 2'b01, 3, 1'b0, 3'd0, '{7, 6, 5, 0, 0, 0}, 3);
    test_limited_run("gray", 2'b10, 4, 1'b0, 3'd0, '{1, 3, 2, 6, 0, 0}, 4);
    test_limited_run("loadwrap", 2'b00, 3, 1'b1, 3'd6, '{7, 0, 1, 0, 0, 0}, 3);
    test_limited_run("ring", 2'b11, 4, 1'b0, 3'd0, '{1, 2, 4, 1, 0, 0}, 4);
    test_pause();
    test_rst_mid();
    test_random(40);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
